dual_issue_scheduler: RTL
=========================

DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: instrd, instrd2  in  32 each  decode-stage instructions, lane 0 (older) and lane 1.
REQ-004 SHALL provide: pairvalidd  in  1  decode pair holds valid instructions.
REQ-005 SHALL provide: regwrited, branchd  in  1 each  lane-0 control; writeregd  in  5  lane-0 destination.
REQ-006 SHALL provide: branchd2  in  1  lane-1 is a branch; pcsrcd  in  1  lane-0 branch taken.
REQ-007 SHALL provide: regwritee, regwritee2, memtorege, memtorege2  in  1 each; writerege, writerege2  in  5 each  execute-stage lanes.
REQ-008 SHALL provide: regwritem, regwritem2  in  1 each; writeregm, writeregm2  in  5 each  memory-stage lanes.
REQ-009 SHALL provide: issue0, issue1  out  1 each  lane issues into execute this cycle.
REQ-010 SHALL provide: stallf, stalld, flushe  out  1 each  hold fetch, hold decode, bubble execute.
REQ-011 SHALL provide: forwardad, forwardbd, forwardad2, forwardbd2  out  2 each  decode operand selects.
REQ-012 SHALL provide: splitcount  out  16  count of split-issued pairs.

Function
REQ-013 SHALL decode rs=instr[25:21], rt=instr[20:16] per lane; register 0 never matches any hazard or forward.
REQ-014 SHALL flag intra-pair dependency when regwrited=1 and writeregd equals rs or rt of instrd2.
REQ-015 SHALL flag load-use hazard for a lane when memtorege (or memtorege2) is 1 and its writerege (writerege2) matches that lane's rs or rt.
REQ-016 SHALL flag branch hazard for a lane with its branch input 1 when regwritee/regwritee2 with a matching writerege/writerege2, or memtorege/memtorege2 case, hits its rs or rt.
REQ-017 SHALL implement two states: NORMAL, SPLIT; reset enters NORMAL.
REQ-018 NORMAL, pairvalidd=0: issue0=issue1=0, no stall, stay.
REQ-019 NORMAL, lane-0 hazard or lane-1 hazard without intra-pair dependency: issue0=issue1=0, stallf=stalld=flushe=1, stay NORMAL.
REQ-020 NORMAL, no lane-0 hazard, intra-pair dependency: issue0=1, issue1=0, stallf=stalld=1, next SPLIT, splitcount increments.
REQ-021 NORMAL, no hazard, no intra-pair dependency: issue0=issue1=1, stay NORMAL.
REQ-022 NORMAL, issue0=1 with pcsrcd=1: issue1 forced 0, no SPLIT entry, splitcount unchanged (lane 1 squashed).
REQ-023 SPLIT: issue0=0; lane-1 hazard gives stallf=stalld=flushe=1, stay SPLIT; else issue1=1, stalls 0, next NORMAL.
REQ-024 forwardad/forwardbd: 10 if regwritem2 and writeregm2 matches lane-0 rs/rt; else 01 if regwritem and writeregm matches; else 00.
REQ-025 forwardad2/forwardbd2: 01 if regwritem2 and writeregm2 matches lane-1 rs/rt; else 10 if regwritem and writeregm matches; else 00 (younger lane-1 M result has priority in both).
REQ-026 Forward selects SHALL be combinational, zero latency, independent of state.
REQ-027 splitcount SHALL saturate at 16'hFFFF.
REQ-028 Stall/issue outputs SHALL be combinational from state and current inputs; state registered.

Reset
REQ-029 While reset=1: issue0=issue1=stallf=stalld=flushe=0, all forward selects 00, splitcount=0, next state NORMAL.
REQ-030 Reset asserted in SPLIT SHALL abandon pending lane 1 and return to NORMAL next edge.

Verification
REQ-031 instrd add $3,$1,$2 (regwrited=1, writeregd=3), instrd2 sub $5,$6,$7 -> issue0=issue1=1, stalls 0, NORMAL.
REQ-032 instrd writes $3, instrd2 reads rs=$3 -> cycle 1: issue0=1, issue1=0, stallf=stalld=1, splitcount 0->1; cycle 2: issue1=1, stalls 0, NORMAL.
REQ-033 memtorege=1, writerege=4, instrd rt=$4 -> stallf=stalld=flushe=1, issue0=issue1=0; next cycle memtorege=0 -> pair issues.
REQ-034 regwritem=1 writeregm=8, regwritem2=1 writeregm2=8, lane-0 rs=$8, lane-1 rt=$8 -> forwardad=10, forwardbd2=01; rs=$0 case -> 00.
REQ-035 intra-pair dependency with pcsrcd=1 -> issue0=1, issue1=0, state NORMAL, splitcount unchanged.
REQ-036 reset pulse while in SPLIT -> all outputs 0 during reset, NORMAL afterwards, splitcount=0.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue decode scheduler: detects intra-pair, load-use and branch hazards,
// splits dependent pairs across two cycles and drives decode-stage forward selects.
module dual_issue_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrd,
  input  logic [31:0] instrd2,
  input  logic        pairvalidd,
  input  logic        regwrited,
  input  logic        branchd,
  input  logic [4:0]  writeregd,
  input  logic        branchd2,
  input  logic        pcsrcd,
  input  logic        regwritee,
  input  logic        regwritee2,
  input  logic        memtorege,
  input  logic        memtorege2,
  input  logic [4:0]  writerege,
  input  logic [4:0]  writerege2,
  input  logic        regwritem,
  input  logic        regwritem2,
  input  logic [4:0]  writeregm,
  input  logic [4:0]  writeregm2,
  output logic        issue0,
  output logic        issue1,
  output logic        stallf,
  output logic        stalld,
  output logic        flushe,
  output logic [1:0]  forwardad,
  output logic [1:0]  forwardbd,
  output logic [1:0]  forwardad2,
  output logic [1:0]  forwardbd2,
  output logic [15:0] splitcount
);

  typedef enum logic {NORMAL = 1'b0, SPLIT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic        split_enter;
  logic [4:0]  rs0, rt0, rs1, rt1;
  logic        intra_dep;
  logic        loaduse0, loaduse1;
  logic        branch0, branch1;
  logic        hazard0, hazard1;
  logic        unused_bits;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic hits(input logic [4:0] dst, input logic [4:0] rs,
                                input logic [4:0] rt);
    return reg_match(dst, rs) || reg_match(dst, rt);
  endfunction

  assign rs0 = instrd[25:21];
  assign rt0 = instrd[20:16];
  assign rs1 = instrd2[25:21];
  assign rt1 = instrd2[20:16];

  assign unused_bits = ^{instrd[31:26], instrd[15:0], instrd2[31:26], instrd2[15:0]};

  assign intra_dep = regwrited && hits(writeregd, rs1, rt1);

  assign loaduse0 = (memtorege  && hits(writerege,  rs0, rt0)) ||
                    (memtorege2 && hits(writerege2, rs0, rt0));
  assign loaduse1 = (memtorege  && hits(writerege,  rs1, rt1)) ||
                    (memtorege2 && hits(writerege2, rs1, rt1));

  // Branches resolve in decode, so any execute-stage producer is a hazard.
  assign branch0 = branchd &&
                   (((regwritee  || memtorege)  && hits(writerege,  rs0, rt0)) ||
                    ((regwritee2 || memtorege2) && hits(writerege2, rs0, rt0)));
  assign branch1 = branchd2 &&
                   (((regwritee  || memtorege)  && hits(writerege,  rs1, rt1)) ||
                    ((regwritee2 || memtorege2) && hits(writerege2, rs1, rt1)));

  assign hazard0 = loaduse0 || branch0;
  assign hazard1 = loaduse1 || branch1;

  always_comb begin
    issue0      = 1'b0;
    issue1      = 1'b0;
    stallf      = 1'b0;
    stalld      = 1'b0;
    flushe      = 1'b0;
    split_enter = 1'b0;
    state_next  = state;
    if (reset) begin
      state_next = NORMAL;
    end else begin
      case (state)
        NORMAL: begin
          if (pairvalidd) begin
            if (hazard0 || (hazard1 && !intra_dep)) begin
              stallf = 1'b1;
              stalld = 1'b1;
              flushe = 1'b1;
            end else if (intra_dep && !pcsrcd) begin
              // Lane 1 waits one cycle; its own hazards are checked in SPLIT.
              issue0      = 1'b1;
              stallf      = 1'b1;
              stalld      = 1'b1;
              split_enter = 1'b1;
              state_next  = SPLIT;
            end else begin
              issue0 = 1'b1;
              issue1 = !pcsrcd;
            end
          end
        end
        SPLIT: begin
          if (hazard1) begin
            stallf = 1'b1;
            stalld = 1'b1;
            flushe = 1'b1;
          end else begin
            issue1     = 1'b1;
            state_next = NORMAL;
          end
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  // Lane 0 prefers the younger M-stage lane; lane 1 uses the opposite encoding.
  always_comb begin
    forwardad  = 2'b00;
    forwardbd  = 2'b00;
    forwardad2 = 2'b00;
    forwardbd2 = 2'b00;
    if (!reset) begin
      if (regwritem2 && reg_match(writeregm2, rs0))     forwardad = 2'b10;
      else if (regwritem && reg_match(writeregm, rs0))  forwardad = 2'b01;
      if (regwritem2 && reg_match(writeregm2, rt0))     forwardbd = 2'b10;
      else if (regwritem && reg_match(writeregm, rt0))  forwardbd = 2'b01;
      if (regwritem2 && reg_match(writeregm2, rs1))     forwardad2 = 2'b01;
      else if (regwritem && reg_match(writeregm, rs1))  forwardad2 = 2'b10;
      if (regwritem2 && reg_match(writeregm2, rt1))     forwardbd2 = 2'b01;
      else if (regwritem && reg_match(writeregm, rt1))  forwardbd2 = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      splitcount <= 16'd0;
    end else begin
      state <= state_next;
      if (split_enter && (splitcount != 16'hFFFF))
        splitcount <= splitcount + 16'd1;
    end
  end

endmodule
